// File: rtl/op_fwd_stage.sv
// Operand-fetch stage: drives RF read ports, resolves operands through EX/MA/WB
// forwarding, stalls ID on load hazards and fills the OP/EX pipeline register.
module op_fwd_stage #(
   parameter int unsigned STALL_CNT_W = 16,
   parameter int unsigned FWD_WB      = 1
) (
   input  logic                   s_clk_i,
   input  logic                   s_resetn_i,
   input  logic                   s_id_valid_i,
   output logic                   s_id_ready_o,
   input  logic [4:0]             s_id_rs1_i,
   input  logic [4:0]             s_id_rs2_i,
   input  logic [4:0]             s_id_rd_i,
   input  logic                   s_id_use1_i,
   input  logic                   s_id_use2_i,
   input  logic                   s_id_wen_i,
   input  logic                   s_id_load_i,
   output logic [4:0]             s_r_p1_add_o,
   output logic [4:0]             s_r_p2_add_o,
   input  logic [31:0]            s_p1_val_i,
   input  logic [31:0]            s_p2_val_i,
   input  logic                   s_ex_wen_i,
   input  logic                   s_ex_load_i,
   input  logic [4:0]             s_ex_add_i,
   input  logic [31:0]            s_ex_val_i,
   input  logic                   s_ma_wen_i,
   input  logic                   s_ma_pend_i,
   input  logic [4:0]             s_ma_add_i,
   input  logic [31:0]            s_ma_val_i,
   input  logic                   s_wb_wen_i,
   input  logic [4:0]             s_wb_add_i,
   input  logic [31:0]            s_wb_val_i,
   input  logic                   s_flush_i,
   input  logic                   s_ex_ready_i,
   output logic                   s_opex_valid_o,
   output logic [4:0]             s_opex_rd_o,
   output logic                   s_opex_wen_o,
   output logic                   s_opex_load_o,
   output logic [31:0]            s_opex_op1_o,
   output logic [31:0]            s_opex_op2_o,
   output logic [STALL_CNT_W-1:0] s_stall_cnt_o
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t      state;
   state_t      state_nxt_c;
   logic        ex_m1_c, ex_m2_c, ma_m1_c, ma_m2_c, wb_m1_c, wb_m2_c;
   logic        hazard_c;
   logic        xfer_c;
   logic [31:0] op1_c, op2_c;

   assign s_r_p1_add_o = s_id_rs1_i;
   assign s_r_p2_add_o = s_id_rs2_i;

   // Producer matches; x0 and unused sources never match
   assign ex_m1_c = s_id_use1_i && (s_id_rs1_i != 5'd0) && s_ex_wen_i && (s_ex_add_i == s_id_rs1_i);
   assign ex_m2_c = s_id_use2_i && (s_id_rs2_i != 5'd0) && s_ex_wen_i && (s_ex_add_i == s_id_rs2_i);
   assign ma_m1_c = s_id_use1_i && (s_id_rs1_i != 5'd0) && s_ma_wen_i && (s_ma_add_i == s_id_rs1_i);
   assign ma_m2_c = s_id_use2_i && (s_id_rs2_i != 5'd0) && s_ma_wen_i && (s_ma_add_i == s_id_rs2_i);
   assign wb_m1_c = (FWD_WB != 0) && s_id_use1_i && (s_id_rs1_i != 5'd0) && s_wb_wen_i
                    && (s_wb_add_i == s_id_rs1_i);
   assign wb_m2_c = (FWD_WB != 0) && s_id_use2_i && (s_id_rs2_i != 5'd0) && s_wb_wen_i
                    && (s_wb_add_i == s_id_rs2_i);

   // A younger EX writer shadows MA, so a pending MA load only stalls when EX does not match
   assign hazard_c = (ex_m1_c && s_ex_load_i) || (ex_m2_c && s_ex_load_i)
                   || (!ex_m1_c && ma_m1_c && s_ma_pend_i)
                   || (!ex_m2_c && ma_m2_c && s_ma_pend_i);

   assign s_id_ready_o = !hazard_c && ((state == EMPTY) || s_ex_ready_i);
   assign xfer_c       = s_id_valid_i && s_id_ready_o && !s_flush_i;

   // Operand selection, youngest producer first
   always_comb begin
      op1_c = s_p1_val_i;
      if (s_id_rs1_i == 5'd0) op1_c = 32'd0;
      else if (ex_m1_c)       op1_c = s_ex_val_i;
      else if (ma_m1_c)       op1_c = s_ma_val_i;
      else if (wb_m1_c)       op1_c = s_wb_val_i;

      op2_c = s_p2_val_i;
      if (s_id_rs2_i == 5'd0) op2_c = 32'd0;
      else if (ex_m2_c)       op2_c = s_ex_val_i;
      else if (ma_m2_c)       op2_c = s_ma_val_i;
      else if (wb_m2_c)       op2_c = s_wb_val_i;
   end

   always_comb begin
      state_nxt_c = EMPTY;
      if (s_flush_i)                           state_nxt_c = EMPTY;
      else if (xfer_c)                         state_nxt_c = FULL;
      else if ((state == FULL) && !s_ex_ready_i) state_nxt_c = FULL;
   end

   assign s_opex_valid_o = (state == FULL);

   // OP/EX register, occupancy state and stall counter
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state         <= EMPTY;
         s_opex_rd_o   <= 5'd0;
         s_opex_wen_o  <= 1'b0;
         s_opex_load_o <= 1'b0;
         s_opex_op1_o  <= 32'd0;
         s_opex_op2_o  <= 32'd0;
         s_stall_cnt_o <= '0;
      end else begin
         state <= state_nxt_c;
         if (s_flush_i) begin
            s_opex_wen_o  <= 1'b0;
            s_opex_load_o <= 1'b0;
         end else if (xfer_c) begin
            s_opex_rd_o   <= s_id_rd_i;
            s_opex_wen_o  <= s_id_wen_i;
            s_opex_load_o <= s_id_load_i;
            s_opex_op1_o  <= op1_c;
            s_opex_op2_o  <= op2_c;
         end
         if (s_id_valid_i && hazard_c && (s_stall_cnt_o != '1))
            s_stall_cnt_o <= s_stall_cnt_o + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_op_fwd_stage.sv
// Self-checking bench for op_fwd_stage: directed scenarios plus a randomized
// run against a stage-list reference model.
module tb_op_fwd_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        id_valid, id_ready;
   logic [4:0]  rs1, rs2, rd, p1_add, p2_add;
   logic        use1, use2, id_wen, id_load;
   logic [31:0] p1_val, p2_val;
   logic        ex_wen, ex_load, ma_wen, ma_pend, wb_wen;
   logic [4:0]  ex_add, ma_add, wb_add;
   logic [31:0] ex_val, ma_val, wb_val;
   logic        flush, ex_ready;
   logic        o_valid, o_wen, o_load;
   logic [4:0]  o_rd;
   logic [31:0] o_op1, o_op2;
   logic [15:0] o_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   op_fwd_stage dut (
      .s_clk_i(clk), .s_resetn_i(resetn),
      .s_id_valid_i(id_valid), .s_id_ready_o(id_ready),
      .s_id_rs1_i(rs1), .s_id_rs2_i(rs2), .s_id_rd_i(rd),
      .s_id_use1_i(use1), .s_id_use2_i(use2), .s_id_wen_i(id_wen), .s_id_load_i(id_load),
      .s_r_p1_add_o(p1_add), .s_r_p2_add_o(p2_add),
      .s_p1_val_i(p1_val), .s_p2_val_i(p2_val),
      .s_ex_wen_i(ex_wen), .s_ex_load_i(ex_load), .s_ex_add_i(ex_add), .s_ex_val_i(ex_val),
      .s_ma_wen_i(ma_wen), .s_ma_pend_i(ma_pend), .s_ma_add_i(ma_add), .s_ma_val_i(ma_val),
      .s_wb_wen_i(wb_wen), .s_wb_add_i(wb_add), .s_wb_val_i(wb_val),
      .s_flush_i(flush), .s_ex_ready_i(ex_ready),
      .s_opex_valid_o(o_valid), .s_opex_rd_o(o_rd), .s_opex_wen_o(o_wen),
      .s_opex_load_o(o_load), .s_opex_op1_o(o_op1), .s_opex_op2_o(o_op2),
      .s_stall_cnt_o(o_cnt)
   );

   task automatic clr_in();
      id_valid = 0; rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0; id_wen = 0; id_load = 0;
      p1_val = 0; p2_val = 0;
      ex_wen = 0; ex_load = 0; ex_add = 0; ex_val = 0;
      ma_wen = 0; ma_pend = 0; ma_add = 0; ma_val = 0;
      wb_wen = 0; wb_add = 0; wb_val = 0;
      flush = 0; ex_ready = 1;
   endtask

   task automatic do_reset();
      clr_in();
      resetn = 0;
      @(posedge clk); #1;
      resetn = 1;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Reference: scan producers youngest-first; the first writer of rs decides value and blocking
   function automatic logic [32:0] m_src(input logic [4:0] rs, input logic use_rs,
                                         input logic [31:0] rf);
      logic        wen_a [3];
      logic [4:0]  add_a [3];
      logic [31:0] val_a [3];
      logic        blk_a [3];
      wen_a[0] = ex_wen; add_a[0] = ex_add; val_a[0] = ex_val; blk_a[0] = ex_load;
      wen_a[1] = ma_wen; add_a[1] = ma_add; val_a[1] = ma_val; blk_a[1] = ma_pend;
      wen_a[2] = wb_wen; add_a[2] = wb_add; val_a[2] = wb_val; blk_a[2] = 1'b0;
      if (rs == 5'd0) return {1'b0, 32'd0};
      if (use_rs)
         for (int i = 0; i < 3; i++)
            if (wen_a[i] && add_a[i] == rs) return {blk_a[i], val_a[i]};
      return {1'b0, rf};
   endfunction

   task automatic test_reset();
      clr_in();
      resetn = 0; #1;
      total++;
      if ({o_valid, o_rd, o_wen, o_load, o_op1, o_op2, o_cnt} !== '0) begin
         bad++; $display("FAIL reset_outputs got v=%b rd=%h op1=%h op2=%h cnt=%h want all 0",
                         o_valid, o_rd, o_op1, o_op2, o_cnt);
      end
      tick(); resetn = 1;
   endtask

   task automatic test_fwd_priority();
      do_reset();
      id_valid = 1; rs1 = 5; use1 = 1; p1_val = 32'h11;
      ma_wen = 1; ma_add = 5; ma_val = 32'h22;
      ex_wen = 1; ex_add = 5; ex_val = 32'h33;
      total++;
      if (p1_add !== 5'd5) begin bad++; $display("FAIL rf_addr got=%h want=05", p1_add); end
      tick();
      total++;
      if (o_valid !== 1'b1 || o_op1 !== 32'h33) begin
         bad++; $display("FAIL fwd_ex got v=%b op1=%h want v=1 op1=33", o_valid, o_op1);
      end
      ex_wen = 0; tick();
      total++;
      if (o_op1 !== 32'h22) begin bad++; $display("FAIL fwd_ma got=%h want=22", o_op1); end
      ma_wen = 0; tick();
      total++;
      if (o_op1 !== 32'h11) begin bad++; $display("FAIL fwd_rf got=%h want=11", o_op1); end
   endtask

   task automatic test_load_use();
      do_reset();
      id_valid = 1; rs2 = 7; use2 = 1; p2_val = 32'h99;
      ex_wen = 1; ex_load = 1; ex_add = 7; ex_val = 32'hDEAD;
      #1;
      total++;
      if (id_ready !== 1'b0) begin bad++; $display("FAIL load_use_ready got=%b want=0", id_ready); end
      tick();
      total++;
      if (o_valid !== 1'b0 || o_cnt !== 16'd1) begin
         bad++; $display("FAIL load_use_bubble got v=%b cnt=%0d want v=0 cnt=1", o_valid, o_cnt);
      end
      ex_wen = 0; ex_load = 0; ma_wen = 1; ma_add = 7; ma_val = 32'hCAFE;
      tick();
      total++;
      if (o_valid !== 1'b1 || o_op2 !== 32'hCAFE || o_cnt !== 16'd1) begin
         bad++; $display("FAIL load_use_release got v=%b op2=%h cnt=%0d want v=1 op2=cafe cnt=1",
                         o_valid, o_op2, o_cnt);
      end
   endtask

   task automatic test_pend_ma();
      do_reset();
      id_valid = 1; rs1 = 3; use1 = 1; p1_val = 32'h1;
      ma_wen = 1; ma_add = 3; ma_pend = 1; ma_val = 32'h1234;
      repeat (3) tick();
      total++;
      if (o_valid !== 1'b0 || o_cnt !== 16'd3) begin
         bad++; $display("FAIL pend_stall got v=%b cnt=%0d want v=0 cnt=3", o_valid, o_cnt);
      end
      ma_pend = 0; ma_val = 32'h5678;
      tick();
      total++;
      if (o_valid !== 1'b1 || o_op1 !== 32'h5678 || o_cnt !== 16'd3) begin
         bad++; $display("FAIL pend_release got v=%b op1=%h cnt=%0d want v=1 op1=5678 cnt=3",
                         o_valid, o_op1, o_cnt);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      id_valid = 1; rs1 = 1; use1 = 1; p1_val = 32'hA1; rd = 4; id_wen = 1;
      tick();
      ex_ready = 0; p1_val = 32'hB2; rd = 6;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (id_ready !== 1'b0) begin bad++; $display("FAIL hold_ready[%0d] got=%b want=0", i, id_ready); end
         tick();
         total++;
         if (o_valid !== 1'b1 || o_op1 !== 32'hA1 || o_rd !== 5'd4 || o_cnt !== 16'd0) begin
            bad++; $display("FAIL hold_stable[%0d] got v=%b op1=%h rd=%0d cnt=%0d want 1 a1 4 0",
                            i, o_valid, o_op1, o_rd, o_cnt);
         end
      end
      ex_ready = 1; #1;
      total++;
      if (id_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", id_ready); end
      tick();
      total++;
      if (o_valid !== 1'b1 || o_op1 !== 32'hB2 || o_rd !== 5'd6) begin
         bad++; $display("FAIL release_next got v=%b op1=%h rd=%0d want 1 b2 6", o_valid, o_op1, o_rd);
      end
   endtask

   task automatic test_x0_wb();
      do_reset();
      id_valid = 1; rs1 = 0; use1 = 1; p1_val = 32'h55;
      ex_wen = 1; ex_add = 0; ex_val = 32'hFFFF;
      rs2 = 9; use2 = 1; p2_val = 32'h77;
      wb_wen = 1; wb_add = 9; wb_val = 32'hABCD;
      tick();
      total++;
      if (o_op1 !== 32'd0 || o_op2 !== 32'hABCD) begin
         bad++; $display("FAIL x0_wb got op1=%h op2=%h want 0 abcd", o_op1, o_op2);
      end
   endtask

   task automatic test_flush();
      do_reset();
      id_valid = 1; rs1 = 2; use1 = 1; p1_val = 32'h42; rd = 8; id_wen = 1; id_load = 1;
      tick();
      total++;
      if (o_valid !== 1'b1 || o_wen !== 1'b1 || o_load !== 1'b1) begin
         bad++; $display("FAIL flush_pre got v=%b wen=%b load=%b want 1 1 1", o_valid, o_wen, o_load);
      end
      flush = 1; ex_ready = 0;
      tick();
      total++;
      if (o_valid !== 1'b0 || o_wen !== 1'b0 || o_load !== 1'b0) begin
         bad++; $display("FAIL flush got v=%b wen=%b load=%b want 0 0 0", o_valid, o_wen, o_load);
      end
      flush = 0;
   endtask

   task automatic test_saturate();
      do_reset();
      id_valid = 1; rs1 = 4; use1 = 1; ex_wen = 1; ex_load = 1; ex_add = 4;
      repeat (65534) @(posedge clk);
      #1;
      total++;
      if (o_cnt !== 16'hFFFE) begin bad++; $display("FAIL cnt_near got=%h want=fffe", o_cnt); end
      repeat (6) @(posedge clk);
      #1;
      total++;
      if (o_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat got=%h want=ffff", o_cnt); end
   endtask

   task automatic test_async_reset();
      do_reset();
      id_valid = 1; rs1 = 1; use1 = 1; p1_val = 32'h3C; rd = 2; id_wen = 1; id_load = 1;
      tick();
      ex_ready = 0; ex_wen = 1; ex_load = 1; ex_add = 1;
      tick(); tick();
      #2; resetn = 0; #1;
      total++;
      if ({o_valid, o_rd, o_wen, o_load, o_op1, o_op2, o_cnt} !== '0) begin
         bad++; $display("FAIL async_reset got v=%b rd=%h op1=%h cnt=%h want all 0",
                         o_valid, o_rd, o_op1, o_cnt);
      end
      tick(); resetn = 1;
   endtask

   task automatic test_random();
      logic        m_full, m_wen, m_load, hz, exp_rdy;
      logic [4:0]  m_rd;
      logic [31:0] m_op1, m_op2;
      logic [32:0] s1, s2;
      int          m_cnt;
      do_reset();
      m_full = 0; m_wen = 0; m_load = 0; m_rd = 0; m_op1 = 0; m_op2 = 0; m_cnt = 0;
      for (int c = 0; c < 400; c++) begin
         id_valid = ($urandom_range(0, 9) < 8); rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 31));
         use1 = 1'($urandom); use2 = 1'($urandom); id_wen = 1'($urandom); id_load = 1'($urandom);
         p1_val = $urandom; p2_val = $urandom;
         ex_wen = 1'($urandom); ex_load = ($urandom_range(0, 9) < 3); ex_add = 5'($urandom_range(0, 7));
         ex_val = $urandom;
         ma_wen = 1'($urandom); ma_pend = ($urandom_range(0, 3) == 0); ma_add = 5'($urandom_range(0, 7));
         ma_val = $urandom;
         wb_wen = 1'($urandom); wb_add = 5'($urandom_range(0, 7)); wb_val = $urandom;
         flush = ($urandom_range(0, 19) == 0); ex_ready = ($urandom_range(0, 9) < 7);
         s1 = m_src(rs1, use1, p1_val);
         s2 = m_src(rs2, use2, p2_val);
         hz = s1[32] || s2[32];
         exp_rdy = !hz && (!m_full || ex_ready);
         #1;
         total++;
         if (id_ready !== exp_rdy || p1_add !== rs1 || p2_add !== rs2) begin
            bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, id_ready, exp_rdy);
         end
         @(posedge clk);
         if (id_valid && hz && m_cnt < 16'hFFFF) m_cnt++;
         if (flush) begin
            m_full = 0; m_wen = 0; m_load = 0;
         end else if (id_valid && exp_rdy) begin
            m_full = 1; m_rd = rd; m_wen = id_wen; m_load = id_load; m_op1 = s1[31:0]; m_op2 = s2[31:0];
         end else if (ex_ready) m_full = 0;
         #1;
         total++;
         if (o_valid !== m_full || o_wen !== m_wen || o_load !== m_load || o_cnt !== 16'(m_cnt)
             || o_rd !== m_rd || o_op1 !== m_op1 || o_op2 !== m_op2) begin
            bad++; $display("FAIL rnd_opex[%0d] got v=%b rd=%0d op1=%h op2=%h cnt=%0d want v=%b rd=%0d op1=%h op2=%h cnt=%0d",
                            c, o_valid, o_rd, o_op1, o_op2, o_cnt, m_full, m_rd, m_op1, m_op2, m_cnt);
         end
      end
   endtask

   initial begin
      clr_in();
      resetn = 1;
      test_reset();
      test_fwd_priority();
      test_load_use();
      test_pend_ma();
      test_backpressure();
      test_x0_wb();
      test_flush();
      test_random();
      test_async_reset();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
